// File: rtl/fhe_arith_pkg.sv
// Shared arithmetic types for the FHE datapath blocks.
package fhe_arith_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  localparam int unsigned PIPE_DEPTH = 2;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef logic [DEF_WIDTH-1:0] coeff_t;

endpackage

// File: rtl/mod_addsub_lane.sv
// One lane of first-stage modular add/sub arithmetic.
// Produces the raw sum/difference s and its modulus-corrected twin d, both WIDTH+1 bits;
// the top bit of each acts as carry/borrow for the second-stage select.
module mod_addsub_lane
  import fhe_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] q,
  input  op_e              op,
  output logic [WIDTH:0]   s,
  output logic [WIDTH:0]   d
);

  logic [WIDTH:0] a_e;
  logic [WIDTH:0] b_e;
  logic [WIDTH:0] q_e;

  assign a_e = {1'b0, a};
  assign b_e = {1'b0, b};
  assign q_e = {1'b0, q};

  // add: s = a + b, d = s - q; sub: s = a - b, d = s + q
  always_comb begin
    s = '0;
    d = '0;
    if (op == OP_SUB) begin
      s = a_e - b_e;
      d = s + q_e;
    end else begin
      s = a_e + b_e;
      d = s - q_e;
    end
  end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined multi-lane modular adder/subtractor with valid/ready on both sides.
// Optional build macro MOD_ADDSUB_RANGE_CHK_EN adds a sticky range_err output flagging
// any accepted operand that is not below the beat's modulus.
module mod_addsub_pipe
  import fhe_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LANES = 4,
  parameter int unsigned TAG_W = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_op,
  input  logic [WIDTH-1:0]       in_q,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [TAG_W-1:0]       out_tag
`ifdef MOD_ADDSUB_RANGE_CHK_EN
  ,
  output logic                   range_err
`endif
);

  localparam int unsigned SW = WIDTH + 1;

  logic             s1_valid;
  op_e              s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic [SW-1:0]    s1_s   [LANES];
  logic [SW-1:0]    s1_d   [LANES];
  logic [SW-1:0]    lane_s [LANES];
  logic [SW-1:0]    lane_d [LANES];

  logic                   s1_adv;
  logic                   s2_adv;
  logic                   in_fire;
  logic [LANES-1:0]       sel_d;
  logic [LANES*WIDTH-1:0] sel_data;
  op_e                    in_op_e;

  // Stage advance chain: S2 frees when empty or drained, S1 when empty or S2 advances
  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid & s1_adv;
  assign in_op_e  = op_e'(in_op);

  // Per-lane first-stage arithmetic
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mod_addsub_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .a (in_a[i*WIDTH +: WIDTH]),
      .b (in_b[i*WIDTH +: WIDTH]),
      .q (in_q),
      .op(in_op_e),
      .s (lane_s[i]),
      .d (lane_d[i])
    );
  end

  // S1 register: capture raw/corrected lane values, op and tag on acceptance
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_tag   <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_s[i] <= '0;
        s1_d[i] <= '0;
      end
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
      end
      if (in_fire) begin
        s1_op  <= in_op_e;
        s1_tag <= in_tag;
        for (int i = 0; i < LANES; i++) begin
          s1_s[i] <= lane_s[i];
          s1_d[i] <= lane_d[i];
        end
      end
    end
  end

  // S2 select: add keeps d unless it went negative without a carry; sub keeps d on borrow
  always_comb begin
    sel_d    = '0;
    sel_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_op == OP_SUB) begin
        sel_d[i] = s1_s[i][WIDTH];
      end else begin
        sel_d[i] = s1_s[i][WIDTH] | ~s1_d[i][WIDTH];
      end
      sel_data[i*WIDTH +: WIDTH] = sel_d[i] ? s1_d[i][WIDTH-1:0] : s1_s[i][WIDTH-1:0];
    end
  end

  // S2 register: output beat, held while downstream stalls
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= sel_data;
        out_tag  <= s1_tag;
      end
    end
  end

`ifdef MOD_ADDSUB_RANGE_CHK_EN
  logic [LANES-1:0] lane_oor;

  // Per-lane operand range comparison against the beat modulus
  always_comb begin
    lane_oor = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_oor[i] = (in_a[i*WIDTH +: WIDTH] >= in_q) | (in_b[i*WIDTH +: WIDTH] >= in_q);
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      range_err <= 1'b0;
    end else if (in_fire && (|lane_oor)) begin
      range_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/mod_addsub_pipe.md
Name: mod_addsub_pipe

Overview:
- Pipelined, multi-lane modular adder/subtractor: out = (a ± b) mod q, per lane.
- Used as the add/sub stage beside NTT butterflies and in RLWE accumulate paths.
- Carries per-transaction modulus and op through the pipe; valid/ready handshake on both sides with full-throughput back-pressure.
- Operands must satisfy a, b < q and q < 2^WIDTH.

Parameters:
- WIDTH, `BIT_WIDTH (common.vh), coefficient/modulus bit width.
- LANES, 4, independent coefficient lanes per beat; all share q and op.
- TAG_W, 8, width of the user tag carried alongside the data.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input accepted when in_valid & in_ready.
- in_op  in  1  0 = add, 1 = sub (a - b).
- in_q  in  WIDTH  modulus for this beat.
- in_a  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH].
- in_b  in  LANES*WIDTH  same packing as in_a.
- in_tag  in  TAG_W  opaque; returned unchanged with the result.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_data  out  LANES*WIDTH  reduced results, same packing.
- out_tag  out  TAG_W  tag of the result beat.

Behaviour:
- Reset: rstn low asynchronously clears both stage valid bits; out_valid = 0, out_data = 0, out_tag = 0, in_ready = 1 after reset release. Reset mid-operation discards all in-flight beats; no partial output.
- Pipeline: two register stages S1, S2. Latency is exactly 2 cycles from acceptance to out_valid with out_ready held high. Throughput is 1 beat/cycle.
- S1 computes per lane with WIDTH+1 bits:
  - add: s = a + b, d = s - q.
  - sub: s = a - b, d = s + q.
  - S1 registers s, d, op and tag.
- S2 selects:
  - add: result = d if (s[WIDTH] | ~d[WIDTH]), else s.
  - sub: result = d if s[WIDTH] (borrow), else s.
  - S2 drives out_data[WIDTH-1:0] per lane; S2 holds its value while stalled.
- Stall: stage k advances when it is empty or stage k+1 advances. S2 advances when ~out_valid | out_ready. in_ready = ~S1_valid | S1_advance (combinational, no dependency on in_valid).
- Data stability: out_data and out_tag must not change while out_valid & ~out_ready.
- Simultaneous accept at input and output in the same cycle with a full pipe: both occur, and occupancy is unchanged.
- Boundaries:
  - a + b = q → 0.
  - a = b (sub) → 0.
  - a = 0, b = q-1 (sub) → 1.
  - Out-of-range operands give unspecified values unless the optional check is enabled.

Optional Feature:
- Macro: MOD_ADDSUB_RANGE_CHK_EN.
- Defined: adds output port range_err (1 bit), a sticky flag.
  - Set the cycle after any accepted beat has a lane with a ≥ q or b ≥ q.
  - Cleared only by rstn.
  - Data path results are unaffected.
- Undefined: the port and its comparators are absent.

Decomposition:
- Shared package fhe_arith_pkg:
  - op_e enum (OP_ADD = 1'b0, OP_SUB = 1'b1).
  - typedef coeff_t = logic [WIDTH-1:0] (default width).
  - localparam PIPE_DEPTH = 2.
- One natural sub-module: mod_addsub_lane, the combinational S1 arithmetic for one lane, instantiated LANES times by generate. S2 select and handshake stay in the top level.

Test Plan (WIDTH=16, LANES=4, q=65521):
- Reset/idle: hold rstn low, then release → out_valid=0, out_data=0, in_ready=1. Add a=65520, b=65520 → out 65519 exactly 2 cycles after accept.
- Sub wrap, all lanes: a={3,0,7,100}, b={5,65520,7,1}, op=sub → {65519,1,0,99}.
- Exact-modulus add: a=65000, b=521 → 0; a=0, b=0 → 0; a=1, b=65519 → 65520.
- Back-pressure: stream 8 beats with tags 0..7 while out_ready toggles 1,0,0,1,... → all 8 results in order, no loss or duplication; out_data stable during stalls; in_ready drops only when both stages are full and stalled.
- Reset mid-stream: assert rstn with 2 beats in flight → out_valid falls immediately; after release, no stale beat appears.
- With MOD_ADDSUB_RANGE_CHK_EN: beat with a=65521 in lane 2 → range_err=1 next cycle and stays 1 through later valid beats until rstn.
